dec_syndrome_compare_pipe: RTL

Pipelined, mode-selectable parity/syndrome comparator for the decoder path. It compares received check bits against recomputed check bits for 8-, 16- or 32-bit codewords and returns three results: an equality flag, the masked syndrome (A XOR B), and a saturating mismatch count. A valid/ready handshake on both sides lets it sit between the parity regenerator and the error-correction stage with back-pressure.

---
 rtl/enc_dec_pkg.sv | 21 ++
 rtl/dec_width_mask.sv | 24 ++
 rtl/dec_syndrome_compare_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/enc_dec_pkg.sv
// Shared codeword-width encoding and active check-bit helper for the decoder path.
// Pure declarations: no latency, no flow control.
package enc_dec_pkg;

    typedef enum logic [1:0] {
        CW8  = 2'b00,
        CW16 = 2'b01,
        CW32 = 2'b10
    } cw_width_e;

    // Bit 1 dominates so that 2'b11 decodes as the widest mode.
    function automatic int active_bits(input logic [1:0] mode, input int max_bits);
        if (mode[1]) begin
            return max_bits;
        end else if (mode[0]) begin
            return max_bits - 1;
        end
        return max_bits - 2;
    endfunction

endpackage

// File: rtl/dec_width_mask.sv
// Maps codeword_width to a mask of active check bits; purely combinational.
// Zero latency, no handshake of its own.
module dec_width_mask
    import enc_dec_pkg::*;
#(
    parameter int MAX_PARITY_BITS = 6
) (
    input  logic [1:0]                 codeword_width,
    output logic [MAX_PARITY_BITS-1:0] mask
);

    int n_active;

    always_comb begin
        n_active = active_bits(codeword_width, MAX_PARITY_BITS);
        mask     = '0;
        for (int i = 0; i < MAX_PARITY_BITS; i++) begin
            if (i < n_active) begin
                mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_syndrome_compare_pipe.sv
// Two-stage masked syndrome compare with saturating mismatch counter; 2-cycle latency.
// Full valid/ready back-pressure: a stage loads when empty or when the stage after it can load.
module dec_syndrome_compare_pipe #(
    parameter int MAX_PARITY_BITS = 6,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MAX_PARITY_BITS-1:0] A,
    input  logic [MAX_PARITY_BITS-1:0] B,
    input  logic [1:0]                 codeword_width,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       isEqual,
    output logic [MAX_PARITY_BITS-1:0] syndrome,
    output logic [CNT_WIDTH-1:0]       mismatch_cnt,
    input  logic                       clr_cnt
);

    logic [MAX_PARITY_BITS-1:0] mask;

    logic                       s1_ld, s2_ld, out_xfer;
    logic                       s1_vld_q, s1_vld_d;
    logic [MAX_PARITY_BITS-1:0] s1_syn_q, s1_syn_d;
    logic                       s2_vld_q, s2_vld_d;
    logic [MAX_PARITY_BITS-1:0] s2_syn_q, s2_syn_d;
    logic                       s2_eq_q, s2_eq_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;

    // Mask is applied on entry so the mode travels with the word implicitly.
    dec_width_mask #(
        .MAX_PARITY_BITS(MAX_PARITY_BITS)
    ) u_width_mask (
        .codeword_width(codeword_width),
        .mask          (mask)
    );

    always_comb begin
        s2_ld    = !s2_vld_q || out_ready;
        s1_ld    = !s1_vld_q || s2_ld;
        out_xfer = s2_vld_q && out_ready;

        s1_vld_d = s1_vld_q;
        s1_syn_d = s1_syn_q;
        s2_vld_d = s2_vld_q;
        s2_syn_d = s2_syn_q;
        s2_eq_d  = s2_eq_q;
        cnt_d    = cnt_q;

        if (s1_ld) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_syn_d = (A ^ B) & mask;
            end
        end

        // Data registers only move on a real word so idle outputs keep the last result.
        if (s2_ld) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_syn_d = s1_syn_q;
                s2_eq_d  = ~|s1_syn_q;
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_xfer && !s2_eq_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_syn_q <= '0;
            s2_vld_q <= 1'b0;
            s2_syn_q <= '0;
            s2_eq_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_syn_q <= s1_syn_d;
            s2_vld_q <= s2_vld_d;
            s2_syn_q <= s2_syn_d;
            s2_eq_q  <= s2_eq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready     = s1_ld;
    assign out_valid    = s2_vld_q;
    assign isEqual      = s2_eq_q;
    assign syndrome     = s2_syn_q;
    assign mismatch_cnt = cnt_q;

endmodule
